// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring
// Magnitudes are divided unsigned; signs are re-applied when the last quotient bit lands.
module div_unit #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        CLK,
  input  logic        nrst,
  input  logic        en,
  input  logic        load_hazard,
  input  logic [1:0]  div_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] res,
  output logic        div_stall,
  output logic        busy
);

  localparam int STEPS = 32 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  count_q;
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic [31:0] rem_q;
  logic [31:0] quot_q;
  logic [31:0] result_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        rem_sel_q;

  logic [31:0] dvd_d;
  logic [31:0] rem_d;
  logic [31:0] quot_d;
  logic [32:0] shifted;
  logic [32:0] diff;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        ovf;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [31:0] fin;

  // Operand decode; -0x80000000 wraps back to 0x80000000, which is the correct magnitude.
  always_comb begin
    is_signed = ~div_op[0];
    a_neg     = is_signed & op_a[31];
    b_neg     = is_signed & op_b[31];
    a_mag     = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag     = b_neg ? (~op_b + 32'd1) : op_b;
    div_zero  = (op_b == 32'd0);
    ovf       = is_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

  // BITS_PER_CYCLE chained restoring steps; bit 32 of diff is the borrow.
  always_comb begin
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    shifted = 33'd0;
    diff    = 33'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      shifted = {rem_d, dvd_d[31]};
      dvd_d   = {dvd_d[30:0], 1'b0};
      diff    = shifted - {1'b0, dsr_q};
      if (!diff[32]) begin
        rem_d  = diff[31:0];
        quot_d = {quot_d[30:0], 1'b1};
      end else begin
        rem_d  = shifted[31:0];
        quot_d = {quot_d[30:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_fix = q_neg_q ? (~quot_d + 32'd1) : quot_d;
    r_fix = r_neg_q ? (~rem_d + 32'd1) : rem_d;
    fin   = rem_sel_q ? r_fix : q_fix;
  end

  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      dvd_q     <= 32'd0;
      dsr_q     <= 32'd0;
      rem_q     <= 32'd0;
      quot_q    <= 32'd0;
      result_q  <= 32'd0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            dvd_q     <= a_mag;
            dsr_q     <= b_mag;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            rem_sel_q <= div_op[1];
            rem_q     <= 32'd0;
            quot_q    <= 32'd0;
            count_q   <= 5'd0;
            if (div_zero) begin
              result_q <= div_op[1] ? op_a : 32'hFFFF_FFFF;
              state_q  <= DONE;
            end else if (ovf) begin
              result_q <= div_op[1] ? 32'd0 : 32'h8000_0000;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          // en low here means the instruction was flushed; drop it silently.
          if (!en) begin
            state_q <= IDLE;
          end else begin
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            count_q <= count_q + 5'd1;
            if (count_q == LAST) begin
              result_q <= fin;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          if (!load_hazard) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_stall = nrst & en & (state_q != DONE);
  assign busy      = (state_q == CALC);
  assign res       = (state_q == DONE) ? result_q : 32'd0;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider: executes DIV, DIVU, REM and REMU in the EX stage, next to the ALU multiplier path.
- Radix-2 restoring algorithm on operand magnitudes, followed by sign correction.
- Freezes the pipeline through a stall output, in the same one-shot style as the multiplier stall.
- Result is valid for exactly one released cycle, then the block is ready for the next divide.

Parameters:
- BITS_PER_CYCLE, 1: quotient bits resolved per CALC cycle. Legal values are 1, 2 and 4. CALC lasts 32/BITS_PER_CYCLE cycles.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nrst  in  1  reset, synchronous and active-low.
- en  in  1  instruction in EX is a divide/remainder. Dropping en mid-operation aborts (flush).
- load_hazard  in  1  pipeline held by a load hazard; extends the DONE state.
- div_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- op_a  in  32  dividend; held stable by the pipeline while div_stall=1.
- op_b  in  32  divisor; held stable by the pipeline while div_stall=1.
- res  out  32  result. Equals the result register in DONE, otherwise 0.
- div_stall  out  1  nrst & en & (state != DONE). Combinational.
- busy  out  1  state == CALC.

Behaviour:
- Reset (nrst=0 at a clock edge): state=IDLE, count=0, result/quotient/remainder registers=0. div_stall=0 while nrst=0; res=0; busy=0. Reset mid-CALC discards the operation.
- States:
  - IDLE, with en=1:
    - Capture abs(op_a) and abs(op_b); magnitude is taken only for DIV/REM.
    - Capture the sign flags: q_neg = a_sign ^ b_sign, r_neg = a_sign.
    - If op_b==0 or signed overflow: load the special result and go to DONE.
    - Otherwise clear the partial remainder, count=0, go to CALC.
  - IDLE, with en=0: stay.
  - CALC:
    - Each cycle shift BITS_PER_CYCLE dividend bits into the partial remainder (MSB first).
    - For each bit, trial-subtract the divisor; if no borrow, keep the difference and set the quotient bit.
    - count increments by 1. After the last cycle (count = 32/BITS_PER_CYCLE - 1), apply sign correction, load the result register and go to DONE.
    - If en=0 in any CALC cycle, go to IDLE; no result is produced.
  - DONE:
    - div_stall=0 and res=result. The pipeline advances on this cycle.
    - Next edge: if load_hazard=1, stay in DONE and keep res stable; else go to IDLE.
- Result selection: DIV/DIVU output the quotient; REM/REMU output the remainder. Quotient is negated if q_neg (DIV only); remainder is negated if r_neg (REM only).
- Special cases (op_b==0 checked first):
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = op_a.
  - Overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- Latency:
  - Normal operation with BITS_PER_CYCLE=1: div_stall high for 33 cycles (IDLE + 32 CALC); res valid in cycle 34.
  - Special cases: stall for 1 cycle; result in cycle 2.
- Back-to-back divides: after DONE→IDLE, en=1 in IDLE starts the new instruction immediately. The new operation's first cycle is that IDLE cycle.
- Width rules:
  - Partial remainder is 33 bits so the borrow is detectable.
  - abs(0x80000000) is handled as unsigned 0x80000000.
  - All arithmetic is modulo 2^32 after correction.

Test Plan:
- DIVU op_a=100, op_b=7 → div_stall high cycles 1-33, busy high 32 cycles, res=14 in cycle 34. REMU with the same operands → 2.
- DIV op_a=-7 (0xFFFFFFF9), op_b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). REM op_a=7, op_b=-2 → 1.
- DIVU op_a=0x1234, op_b=0 → 1 stall cycle, res=0xFFFFFFFF. REMU with the same operands → 0x1234, busy never asserted.
- DIV 0x80000000 / 0xFFFFFFFF → res=0x80000000 after 1 stall cycle. REM with the same operands → 0. DIVU with the same operands → 0.
- Two consecutive DIVU (100/7 then 50/5), with load_hazard=1 for 2 cycles during the first DONE → res=14 held 3 cycles, then second result 10 after a fresh 33-cycle stall.
- Abort and reset:
  - Drop en at CALC cycle 10 → IDLE next cycle, div_stall=0. A new DIVU 9/3 then gives 3 with full latency.
  - nrst=0 mid-CALC → IDLE, res=0, div_stall=0.
